// File: rtl/pe_config_sequencer.sv
// PE-array configuration sequencer: clears the PE array, streams NUM_PE*num_ctx config words
// into the PEs (PE-major order) with one-hot init strobes, then drives the broadcast run strobe
// for num_ctx cycles per iteration, rewinding the PE run counters between iterations.
module pe_config_sequencer #(
  parameter int unsigned NUM_PE = 16,
  parameter int unsigned INST_W = 48,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ITER_W = 16,
  localparam int unsigned CtxW  = $clog2(DEPTH + 1),
  localparam int unsigned PeW   = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [CtxW-1:0]   num_ctx_i,
  input  logic [ITER_W-1:0] num_iter_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [INST_W-1:0] cfg_data_i,
  output logic [INST_W-1:0] pe_inst_o,
  output logic [NUM_PE-1:0] pe_init_o,
  output logic              pe_run_o,
  output logic              pe_rst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [2:0] {StIdle, StClr, StLoad, StRun, StRwnd, StDone} state_e;

  state_e              state_q, state_d;
  logic [CtxW-1:0]     num_ctx_q, num_ctx_d;
  logic [ITER_W-1:0]   num_iter_q, num_iter_d;
  logic [PeW-1:0]      pe_idx_q, pe_idx_d;
  logic [CtxW-1:0]     ctx_idx_q, ctx_idx_d;
  logic [CtxW-1:0]     run_cnt_q, run_cnt_d;
  logic [ITER_W-1:0]   iter_cnt_q, iter_cnt_d;
  logic [INST_W-1:0]   pe_inst_q, pe_inst_d;
  logic [NUM_PE-1:0]   pe_init_q, pe_init_d;
  logic                pe_run_q, pe_run_d;
  logic                pe_rst_q, pe_rst_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                cfg_bad;
  logic [CtxW-1:0]     last_ctx;
  logic                more_iter;

  assign cfg_bad   = (num_ctx_i == '0) || (num_ctx_i > CtxW'(DEPTH)) || (num_iter_i == '0);
  assign last_ctx  = num_ctx_q - CtxW'(1);
  // Widened by one bit so iter_cnt+1 cannot overflow the compare.
  assign more_iter = ({1'b0, iter_cnt_q} + {{ITER_W{1'b0}}, 1'b1}) < {1'b0, num_iter_q};

  // Next-state and registered-output decode; abort overrides every other transition.
  always_comb begin
    state_d    = state_q;
    num_ctx_d  = num_ctx_q;
    num_iter_d = num_iter_q;
    pe_idx_d   = pe_idx_q;
    ctx_idx_d  = ctx_idx_q;
    run_cnt_d  = run_cnt_q;
    iter_cnt_d = iter_cnt_q;
    pe_inst_d  = pe_inst_q;
    pe_init_d  = '0;
    pe_run_d   = 1'b0;
    pe_rst_d   = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (abort_i && (state_q != StIdle)) begin
      state_d  = StIdle;
      pe_rst_d = 1'b1;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          busy_d = 1'b0;
          if (start_i) begin
            if (cfg_bad) begin
              err_d = 1'b1;
            end else begin
              num_ctx_d  = num_ctx_i;
              num_iter_d = num_iter_i;
              pe_idx_d   = '0;
              ctx_idx_d  = '0;
              run_cnt_d  = '0;
              iter_cnt_d = '0;
              busy_d     = 1'b1;
              state_d    = StClr;
            end
          end
        end
        StClr: begin
          pe_rst_d = 1'b1;
          state_d  = StLoad;
        end
        StLoad: begin
          if (cfg_valid_i) begin
            pe_inst_d = cfg_data_i;
            pe_init_d = NUM_PE'(1) << pe_idx_q;
            if (ctx_idx_q == last_ctx) begin
              ctx_idx_d = '0;
              if (pe_idx_q == PeW'(NUM_PE - 1)) begin
                state_d = StRun;
              end else begin
                pe_idx_d = pe_idx_q + PeW'(1);
              end
            end else begin
              ctx_idx_d = ctx_idx_q + CtxW'(1);
            end
          end
        end
        StRun: begin
          pe_run_d = 1'b1;
          if (run_cnt_q == last_ctx) begin
            run_cnt_d = '0;
            state_d   = more_iter ? StRwnd : StDone;
          end else begin
            run_cnt_d = run_cnt_q + CtxW'(1);
          end
        end
        StRwnd: begin
          // PE run counters do not wrap; rewind them before the next pass.
          pe_rst_d   = 1'b1;
          iter_cnt_d = iter_cnt_q + ITER_W'(1);
          state_d    = StRun;
        end
        StDone: begin
          // busy stays high through the done pulse and drops in IDLE.
          done_d  = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      num_ctx_q  <= '0;
      num_iter_q <= '0;
      pe_idx_q   <= '0;
      ctx_idx_q  <= '0;
      run_cnt_q  <= '0;
      iter_cnt_q <= '0;
      pe_inst_q  <= '0;
      pe_init_q  <= '0;
      pe_run_q   <= 1'b0;
      pe_rst_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_ctx_q  <= num_ctx_d;
      num_iter_q <= num_iter_d;
      pe_idx_q   <= pe_idx_d;
      ctx_idx_q  <= ctx_idx_d;
      run_cnt_q  <= run_cnt_d;
      iter_cnt_q <= iter_cnt_d;
      pe_inst_q  <= pe_inst_d;
      pe_init_q  <= pe_init_d;
      pe_run_q   <= pe_run_d;
      pe_rst_q   <= pe_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign cfg_ready_o = (state_q == StLoad);
  assign pe_inst_o   = pe_inst_q;
  assign pe_init_o   = pe_init_q;
  assign pe_run_o    = pe_run_q;
  assign pe_rst_o    = pe_rst_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_pe_config_sequencer.sv
// Bench for pe_config_sequencer: a job-level timeline model predicts every output each cycle,
// directed scenarios pin the model with literal counts, then a randomized soak runs.
module tb_pe_config_sequencer;
  localparam int NumPe = 16;
  localparam int InstW = 48;
  localparam int Depth = 4;
  localparam int IterW = 16;
  localparam int CtxW  = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_i, abort_i, cfg_valid_i;
  logic [CtxW-1:0]  num_ctx_i;
  logic [IterW-1:0] num_iter_i;
  logic [InstW-1:0] cfg_data_i;
  logic             cfg_ready_o;
  logic [InstW-1:0] pe_inst_o;
  logic [NumPe-1:0] pe_init_o;
  logic             pe_run_o, pe_rst_o, busy_o, done_o, err_o;

  always #5 clk = ~clk;

  pe_config_sequencer #(
    .NUM_PE(NumPe),
    .INST_W(InstW),
    .DEPTH (Depth),
    .ITER_W(IterW)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .num_ctx_i  (num_ctx_i),
    .num_iter_i (num_iter_i),
    .cfg_valid_i(cfg_valid_i),
    .cfg_ready_o(cfg_ready_o),
    .cfg_data_i (cfg_data_i),
    .pe_inst_o  (pe_inst_o),
    .pe_init_o  (pe_init_o),
    .pe_run_o   (pe_run_o),
    .pe_rst_o   (pe_rst_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Job timeline model: a job started in cycle t0 loads from t0+2; after the last accept in
  // cycle tlast, iteration i runs on cycles tlast+2+i*(nctx+1) .. +nctx-1, rewinds on the next.
  bit               m_active = 1'b0;
  bit               m_loaded = 1'b0;
  int               m_t0, m_nctx, m_niter, m_nacc, m_tlast;
  logic [InstW-1:0] m_inst = '0;
  logic [NumPe-1:0] cur_init = '0;
  logic [NumPe-1:0] nxt_init;
  bit               cur_err = 1'b0, nxt_err;
  bit               cur_arst = 1'b0, nxt_arst;

  // Observations for the directed literal checks.
  int               run_obs, rst_obs, err_obs, done_obs, init_obs;
  int               first_run_cyc, last_init_cyc;
  int               word_idx = 0;
  logic [InstW-1:0] rec_inst [128];
  logic [NumPe-1:0] rec_init [128];

  int  vmode = 0;
  bit  rand_data = 1'b0;
  bit  tog = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int tdone();
    return m_tlast + 2 + (m_niter - 1) * (m_nctx + 1) + m_nctx;
  endfunction

  function automatic bit in_job(int c);
    return m_active && (c >= m_t0 + 1) && (!m_loaded || c < tdone());
  endfunction

  function automatic bit e_run(int c);
    int rel;
    if (!(m_active && m_loaded)) return 1'b0;
    rel = c - (m_tlast + 2);
    if (rel < 0) return 1'b0;
    return (rel / (m_nctx + 1) < m_niter) && (rel % (m_nctx + 1) < m_nctx);
  endfunction

  function automatic bit e_rwnd(int c);
    int rel;
    if (!(m_active && m_loaded)) return 1'b0;
    rel = c - (m_tlast + 2);
    if (rel < 0) return 1'b0;
    return (rel / (m_nctx + 1) < m_niter - 1) && (rel % (m_nctx + 1) == m_nctx);
  endfunction

  // Compare process: check this cycle against the model, then advance the model.
  always @(negedge clk) begin
    int c;
    bit ij, e_busy, e_ready, e_rstv, e_done;
    c = cyc;
    if (chk_en) begin
      e_busy  = m_active && (c >= m_t0 + 1) && (!m_loaded || c <= tdone());
      e_ready = m_active && !m_loaded && (c >= m_t0 + 2);
      e_rstv  = cur_arst || (m_active && c == m_t0 + 2) || e_rwnd(c);
      e_done  = m_active && m_loaded && (c == tdone());
      chk("busy", 64'(busy_o), 64'(e_busy));
      chk("cfg_ready", 64'(cfg_ready_o), 64'(e_ready));
      chk("pe_rst", 64'(pe_rst_o), 64'(e_rstv));
      chk("pe_run", 64'(pe_run_o), 64'(e_run(c)));
      chk("done", 64'(done_o), 64'(e_done));
      chk("err", 64'(err_o), 64'(cur_err));
      chk("pe_init", 64'(pe_init_o), 64'(cur_init));
      chk("pe_inst", 64'(pe_inst_o), 64'(m_inst));
      if (pe_run_o) begin
        run_obs++;
        if (first_run_cyc < 0) first_run_cyc = c;
      end
      if (pe_rst_o) rst_obs++;
      if (err_o) err_obs++;
      if (done_o) done_obs++;
      if (pe_init_o != '0) begin
        if (init_obs < 128) begin
          rec_inst[init_obs] = pe_inst_o;
          rec_init[init_obs] = pe_init_o;
        end
        init_obs++;
        last_init_cyc = c;
      end
    end
    if (cfg_valid_i && cfg_ready_o) word_idx++;

    ij       = in_job(c);
    nxt_init = '0;
    nxt_err  = 1'b0;
    nxt_arst = 1'b0;
    if (rst) begin
      m_active = 1'b0;
      m_loaded = 1'b0;
      m_inst   = '0;
    end else if (ij && abort_i) begin
      m_active = 1'b0;
      nxt_arst = 1'b1;
    end else if (ij) begin
      if (!m_loaded && c >= m_t0 + 2 && cfg_valid_i) begin
        m_inst = cfg_data_i;
        nxt_init[m_nacc / m_nctx] = 1'b1;
        m_nacc++;
        if (m_nacc == NumPe * m_nctx) begin
          m_loaded = 1'b1;
          m_tlast  = c;
        end
      end
    end else begin
      m_active = 1'b0;
      if (start_i) begin
        if (int'(num_ctx_i) == 0 || int'(num_ctx_i) > Depth || int'(num_iter_i) == 0) begin
          nxt_err = 1'b1;
        end else begin
          m_active = 1'b1;
          m_loaded = 1'b0;
          m_t0     = c;
          m_nctx   = int'(num_ctx_i);
          m_niter  = int'(num_iter_i);
          m_nacc   = 0;
        end
      end
    end
    cur_init = nxt_init;
    cur_err  = nxt_err;
    cur_arst = nxt_arst;
  end

  task automatic tick();
    logic [63:0] r;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    abort_i = 1'b0;
    rst     = 1'b0;
    case (vmode)
      0:       cfg_valid_i = 1'b1;
      1:       begin tog = !tog; cfg_valid_i = tog; end
      default: cfg_valid_i = 1'($urandom_range(0, 1));
    endcase
    r = {$urandom(), $urandom()};
    cfg_data_i = rand_data ? r[InstW-1:0] : InstW'(word_idx);
  endtask

  task automatic do_start(input int nc, input int ni);
    start_i    = 1'b1;
    num_ctx_i  = CtxW'(nc);
    num_iter_i = IterW'(ni);
    tick();
  endtask

  task automatic clear_obs();
    run_obs = 0; rst_obs = 0; err_obs = 0; done_obs = 0; init_obs = 0;
    first_run_cyc = -1; last_init_cyc = -1;
    word_idx = 0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((m_active || busy_o) && n < 3000) begin
      tick();
      n++;
    end
    chk({name, "_timeout"}, 64'(n < 3000), 64'(1));
    repeat (2) tick();
  endtask

  initial begin
    int n;
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; cfg_valid_i = 1'b0;
    cfg_data_i = '0; num_ctx_i = '0; num_iter_i = '0;
    clear_obs();
    tick();
    chk_en = 1'b1;
    chk("reset_busy", 64'(busy_o), 64'(0));
    chk("reset_pe_inst", 64'(pe_inst_o), 64'(0));
    chk("reset_cfg_ready", 64'(cfg_ready_o), 64'(0));
    tick();

    // Nominal: 2 contexts, 1 iteration, data = word index.
    vmode = 0; rand_data = 1'b0; clear_obs();
    do_start(2, 1);
    wait_idle("nominal");
    chk("nom_init_cnt", 64'(init_obs), 64'(32));
    chk("nom_run_cnt", 64'(run_obs), 64'(2));
    chk("nom_rst_cnt", 64'(rst_obs), 64'(1));
    chk("nom_done_cnt", 64'(done_obs), 64'(1));
    chk("nom_w11_data", 64'(rec_inst[11]), 64'(11));
    chk("nom_w11_pe", 64'(rec_init[11]), 64'(16'h0020));
    chk("nom_w30_pe", 64'(rec_init[30]), 64'(16'h8000));
    chk("nom_run_after_init", 64'(first_run_cyc - last_init_cyc), 64'(1));

    // Backpressure: cfg_valid toggling, 3 contexts.
    vmode = 1; clear_obs();
    do_start(3, 1);
    wait_idle("backpressure");
    chk("bp_init_cnt", 64'(init_obs), 64'(48));
    chk("bp_w23_data", 64'(rec_inst[23]), 64'(23));
    chk("bp_w23_pe", 64'(rec_init[23]), 64'(16'h0080));
    chk("bp_w47_data", 64'(rec_inst[47]), 64'(47));

    // Iterations: 4 contexts x 3 iterations.
    vmode = 0; clear_obs();
    do_start(4, 3);
    wait_idle("iter");
    chk("iter_run_cnt", 64'(run_obs), 64'(12));
    chk("iter_rst_cnt", 64'(rst_obs), 64'(3));
    chk("iter_done_cnt", 64'(done_obs), 64'(1));

    // Illegal starts.
    clear_obs();
    do_start(0, 1); tick();
    do_start(5, 1); tick();
    do_start(2, 0); tick(); tick();
    chk("illegal_err_cnt", 64'(err_obs), 64'(3));
    chk("illegal_rst_cnt", 64'(rst_obs), 64'(0));

    // Abort during LOAD after 10 words.
    clear_obs();
    do_start(2, 1);
    n = 0;
    while (init_obs < 10 && n < 200) begin tick(); n++; end
    chk("abort_load_reach", 64'(init_obs >= 10), 64'(1));
    abort_i = 1'b1;
    tick();
    repeat (3) tick();
    chk("abort_load_done", 64'(done_obs), 64'(0));
    chk("abort_load_rst", 64'(rst_obs), 64'(2));

    // Abort during RUN.
    clear_obs();
    do_start(4, 2);
    n = 0;
    while (run_obs < 2 && n < 300) begin tick(); n++; end
    chk("abort_run_reach", 64'(run_obs >= 2), 64'(1));
    abort_i = 1'b1;
    tick();
    repeat (3) tick();
    chk("abort_run_done", 64'(done_obs), 64'(0));
    chk("abort_run_rst", 64'(rst_obs), 64'(2));
    clear_obs();
    do_start(1, 2);
    wait_idle("after_abort");
    chk("after_abort_done", 64'(done_obs), 64'(1));

    // Reset mid-RUN.
    clear_obs();
    do_start(2, 2);
    n = 0;
    while (!pe_run_o && n < 300) begin tick(); n++; end
    rst = 1'b1;
    tick();
    chk("midrst_busy", 64'(busy_o), 64'(0));
    chk("midrst_run", 64'(pe_run_o), 64'(0));
    chk("midrst_inst", 64'(pe_inst_o), 64'(0));
    tick();
    clear_obs();
    do_start(1, 1);
    wait_idle("after_rst");
    chk("after_rst_done", 64'(done_obs), 64'(1));

    // Randomized soak.
    vmode = 2; rand_data = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        start_i    = 1'b1;
        num_ctx_i  = CtxW'($urandom_range(0, 5));
        num_iter_i = IterW'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 249) == 0) abort_i = 1'b1;
      if ($urandom_range(0, 1499) == 0) rst = 1'b1;
      tick();
    end
    wait_idle("random_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pe_config_sequencer.md
Name: pe_config_sequencer

Overview:
- Controller for the PE array that sequences every PE's configuration buffer.
- Streams instruction words from a config source into the PEs one at a time using per-PE init strobes.
- Then drives the broadcast run strobe for the configured number of contexts, and repeats that run for N iterations.
- Between iterations it rewinds each PE's run counter with a one-cycle PE reset pulse. The PE run counter does not wrap, so this pulse is mandatory.

Parameters:
- NUM_PE, 16, number of PEs driven (width of pe_init)
- INST_W, 48, PE instruction width (fu_opcode 4 + switch_9x7 28 + switch_5x4 12 + reg_file_sel 4)
- DEPTH, 4, per-PE config buffer depth; max contexts
- ITER_W, 16, iteration counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  begin a load+run job; sampled in IDLE only
- abort  in  1  terminate the current job
- num_ctx  in  clog2(DEPTH+1)  contexts per PE (1..DEPTH); captured at start
- num_iter  in  ITER_W  run iterations (>=1); captured at start
- cfg_valid  in  1  config word available
- cfg_ready  out  1  sequencer accepts a config word
- cfg_data  in  INST_W  config word
- pe_inst  out  INST_W  instruction broadcast to all PEs
- pe_init  out  NUM_PE  one-hot init strobe, one bit per PE
- pe_run  out  1  broadcast run strobe
- pe_rst  out  1  PE-array reset pulse; ORed with rst at the array
- busy  out  1  job in progress
- done  out  1  one-cycle pulse when the job completes
- err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset: state IDLE; cfg_ready, pe_init, pe_run, pe_rst, busy, done, err all 0; pe_inst 0; all counters 0.
- All outputs are registered, except cfg_ready, which is the decode (state==LOAD).
- States: IDLE, CLR, LOAD, RUN, RWND, DONE.
- IDLE:
  - start=1 with num_ctx==0, num_ctx>DEPTH or num_iter==0: err=1 next cycle; stay IDLE.
  - Otherwise capture num_ctx and num_iter, go to CLR; busy=1 from the next cycle.
- CLR: pe_rst=1 for exactly one cycle (clears PE init_count and run_count); go to LOAD.
- LOAD:
  - cfg_ready=1; a word is accepted when cfg_valid & cfg_ready.
  - Stream order is PE-major: PE0 ctx0..ctx(num_ctx-1), then PE1, and so on. Total NUM_PE*num_ctx words.
  - A word accepted in cycle k drives pe_inst=cfg_data and pe_init=one-hot(pe_idx) in cycle k+1.
  - pe_init=0 in any cycle following no accept; pe_inst holds its last value.
  - ctx_idx counts 0..num_ctx-1; it wraps to 0 and increments pe_idx.
  - On the last accept, cfg_ready drops in k+1 and the state goes to RUN.
- RUN:
  - pe_run=1 for exactly num_ctx consecutive cycles. The first high cycle is k+2, one cycle after the last pe_init.
  - After the final run cycle: if iter_cnt+1 < num_iter, go to RWND; else go to DONE.
- RWND: pe_rst=1 for one cycle, iter_cnt increments, return to RUN.
  - Config buffers are not cleared by pe_rst, so no reload is needed.
- DONE: done=1 for one cycle, busy=0 in the following cycle, state IDLE.
- start while not in IDLE is ignored.
- abort in any non-IDLE state:
  - Next cycle: pe_run=0, pe_init=0, cfg_ready=0, pe_rst=1 for one cycle.
  - Then IDLE with busy=0; done is not asserted.
  - abort in IDLE has no effect. abort has priority over every other transition.
- cfg_valid outside LOAD is ignored; no word is consumed.
- rst mid-job: immediate return to reset values; partial PE contents are undefined to software.

Test Plan:
- Nominal load: start, num_ctx=2, num_iter=1, NUM_PE=16, cfg_valid held high with data=word index → pe_rst pulse, then 32 pe_init cycles. PE p receives words 2p and 2p+1. pe_run is high for 2 cycles starting one cycle after the last pe_init; done pulses; busy falls.
- Backpressure: cfg_valid toggles 1,0,1,0 during LOAD → pe_init is asserted only in cycles following an accept; no word is lost or duplicated; pe_idx advances only every num_ctx accepts.
- Iterations: num_ctx=4, num_iter=3 → pe_run pattern is 4 high, pe_rst 1, 4 high, pe_rst 1, 4 high, then done. Exactly 12 pe_run cycles and 2 RWND pulses.
- Illegal config: start with num_ctx=0, then num_ctx=5 (DEPTH=4), then num_iter=0 → err pulses once each; busy stays 0; pe_rst never asserted.
- Abort during LOAD after 10 words, and again during RUN → one pe_rst pulse, outputs quiet, busy=0, no done. A subsequent legal start runs normally.
- Reset mid-RUN: rst asserted for one cycle → all outputs at reset values in the next cycle; start is accepted afterwards.
